// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - size encodings, FSM states and access-error check for mem_access_ctrl
// MEM_ACCESS_SUBWORD_EN adds the read-modify-write states and byte/half legality.
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WR     = 3'd2,
`ifdef MEM_ACCESS_SUBWORD_EN
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
`endif
    RESP   = 3'd5
  } state_t;

  // Everything above the decoded word-address bits must be zero.
  function automatic logic access_error(input logic [1:0] size, input logic [31:0] addr,
                                        input int ram_bits);
    logic out_of_range;
    out_of_range = (addr >> (ram_bits + 2)) != 32'd0;
`ifdef MEM_ACCESS_SUBWORD_EN
    case (size)
      SIZE_BYTE: access_error = out_of_range;
      SIZE_HALF: access_error = out_of_range || addr[0];
      SIZE_WORD: access_error = out_of_range || (addr[1:0] != 2'b00);
      default:   access_error = 1'b1;
    endcase
`else
    access_error = out_of_range || (size != SIZE_WORD) || (addr[1:0] != 2'b00);
`endif
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - CPU request/response and memory-side signals of mem_access_ctrl
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_read, mem_write
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/byte_lane_unit.sv
// rtl/byte_lane_unit.sv - little-endian lane extract/extend for loads and lane merge for stores
module byte_lane_unit
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_data
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel    = rdata[{addr_lo, 3'b000} +: 8];
    half_sel    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    load_data   = rdata;
    merged_data = wdata;
    case (size)
      SIZE_BYTE: begin
        load_data   = {{24{sign_ext & byte_sel[7]}}, byte_sel};
        merged_data = rdata;
        merged_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SIZE_HALF: begin
        load_data   = {{16{sign_ext & half_sel[15]}}, half_sel};
        merged_data = rdata;
        merged_data[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data   = rdata;
        merged_data = wdata;
      end
    endcase
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - CPU load/store front end to a word-wide, combinational-read memory
// Byte/half accesses (read-modify-write stores) exist only when MEM_ACCESS_SUBWORD_EN is defined.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int RAM_SIZE_BIT = 8
) (
  input logic              clk,
  input logic              reset,
  mem_access_ctrl_if.slave bus
);
  state_t      state_q, state_d;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        accept;
  logic        req_err;
  logic [31:0] lane_load;
  logic [31:0] lane_merged;
`ifdef MEM_ACCESS_SUBWORD_EN
  logic [31:0] merge_q;
`endif

  assign accept  = (state_q == IDLE) && bus.req_valid;
  assign req_err = access_error(bus.req_size, bus.req_addr, RAM_SIZE_BIT);

  byte_lane_unit u_lane (
    .size        (r_size),
    .sign_ext    (r_signed),
    .addr_lo     (r_addr[1:0]),
    .rdata       (bus.mem_rdata),
    .wdata       (r_wdata),
    .load_data   (lane_load),
    .merged_data (lane_merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_err)             state_d = RESP;
          else if (!bus.req_write) state_d = RD;
`ifdef MEM_ACCESS_SUBWORD_EN
          else if (bus.req_size != SIZE_WORD) state_d = RMW_RD;
`endif
          else                     state_d = WR;
        end
      end
      RD, WR:  state_d = RESP;
`ifdef MEM_ACCESS_SUBWORD_EN
      RMW_RD:  state_d = RMW_WR;
      RMW_WR:  state_d = RESP;
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset size to word so the lane merge passes the cleared write data straight through.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write  <= 1'b0;
      r_size   <= SIZE_WORD;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef MEM_ACCESS_SUBWORD_EN
      merge_q  <= '0;
`endif
    end else begin
      if (accept) begin
        r_write  <= bus.req_write;
        r_size   <= bus.req_size;
        r_signed <= bus.req_signed;
        r_addr   <= bus.req_addr;
        r_wdata  <= bus.req_wdata;
        err_q    <= req_err;
      end
      if (state_q == RD) rdata_q <= lane_load;
`ifdef MEM_ACCESS_SUBWORD_EN
      if (state_q == RMW_RD) merge_q <= lane_merged;
`endif
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_err   = (state_q == RESP) && err_q;
  assign bus.resp_rdata = (r_write || err_q) ? 32'd0 : rdata_q;
  assign bus.mem_addr   = {r_addr[31:2], 2'b00};

`ifdef MEM_ACCESS_SUBWORD_EN
  assign bus.mem_read  = (state_q == RD) || (state_q == RMW_RD);
  assign bus.mem_write = (state_q == WR) || (state_q == RMW_WR);
  assign bus.mem_wdata = (state_q == RMW_WR) ? merge_q : lane_merged;
`else
  assign bus.mem_read  = (state_q == RD);
  assign bus.mem_write = (state_q == WR);
  assign bus.mem_wdata = lane_merged;
`endif
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl (RAM_SIZE_BIT = 8)
module tb_mem_access_ctrl;
  import mem_access_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   rd_pulses = 0;
  int   wr_pulses = 0;
  int   resp_pulses = 0;
  int   both_high = 0;

  logic [31:0] mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.RAM_SIZE_BIT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.mem_write) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
  end

  always @(negedge clk) begin
    if (bus.mem_read) rd_pulses++;
    if (bus.mem_write) wr_pulses++;
    if (bus.resp_valid) resp_pulses++;
    if (bus.mem_read && bus.mem_write) both_high++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_we = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // Called at a negedge; leaves at the negedge after the response.
  task automatic run_req(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd, input int exp_lat,
                         input logic exp_err, input logic [31:0] exp_rdata,
                         input int exp_rd, input int exp_wr);
    int          lat;
    int          rd0;
    int          wr0;
    logic        got_err;
    logic [31:0] got_rdata;
    lat = 0;
    got_err = 1'bx;
    got_rdata = 'x;
    check({tag, "/ready"}, 32'(bus.req_ready), 32'd1);
    rd0 = rd_pulses;
    wr0 = wr_pulses;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_size = sz;
    bus.req_signed = sg;
    bus.req_addr = addr;
    bus.req_wdata = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_write = ~wr;
    bus.req_size = ~sz;
    bus.req_signed = ~sg;
    bus.req_addr = ~addr;
    bus.req_wdata = ~wd;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = i;
        got_err = bus.resp_err;
        got_rdata = bus.resp_rdata;
      end
    end
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/err"}, 32'(got_err), 32'(exp_err));
    check({tag, "/rdata"}, got_rdata, exp_rdata);
    @(negedge clk);
    check({tag, "/resp_one_cycle"}, 32'(bus.resp_valid), 32'd0);
    check({tag, "/ready_after"}, 32'(bus.req_ready), 32'd1);
    check({tag, "/mem_read_pulses"}, 32'(rd_pulses - rd0), 32'(exp_rd));
    check({tag, "/mem_write_pulses"}, 32'(wr_pulses - wr0), 32'(exp_wr));
  endtask

  initial begin
    int          wr0;
    int          resp0;
    logic [31:0] exp_final;
    reset = 1'b1;
    pre_we = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size = SIZE_WORD;
    bus.req_signed = 1'b0;
    bus.req_addr = 32'h0000_0080;
    bus.req_wdata = 32'h1111_1111;

    preload(8'h10, 32'hDEAD_BEEF);
    preload(8'h11, 32'h0102_0304);
    preload(8'h20, 32'h0000_0000);
    preload(8'h21, 32'h0BAD_F00D);
    preload(8'hFF, 32'h0000_0000);
    @(negedge clk);
    check("rst/req_ready", 32'(bus.req_ready), 32'd1);
    check("rst/resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst/resp_err", 32'(bus.resp_err), 32'd0);
    check("rst/mem_read", 32'(bus.mem_read), 32'd0);
    check("rst/mem_write", 32'(bus.mem_write), 32'd0);
    check("rst/resp_rdata", bus.resp_rdata, 32'd0);
    check("rst/mem_addr", bus.mem_addr, 32'd0);
    check("rst/mem_wdata", bus.mem_wdata, 32'd0);
    check("rst/mem20_untouched", mem[8'h20], 32'd0);
    bus.req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    run_req("word_load_40", 1'b0, SIZE_WORD, 1'b0, 32'h40, 32'h0, 2, 1'b0, 32'hDEAD_BEEF, 1, 0);
    run_req("word_store_80", 1'b1, SIZE_WORD, 1'b0, 32'h80, 32'hCAFE_F00D, 2, 1'b0, 32'h0, 0, 1);
    check("word_store_80/mem", mem[8'h20], 32'hCAFE_F00D);
    run_req("word_load_80", 1'b0, SIZE_WORD, 1'b1, 32'h80, 32'h0, 2, 1'b0, 32'hCAFE_F00D, 1, 0);
    run_req("word_store_3fc", 1'b1, SIZE_WORD, 1'b0, 32'h3FC, 32'h1357_9BDF, 2, 1'b0, 32'h0, 0, 1);
    check("word_store_3fc/mem", mem[8'hFF], 32'h1357_9BDF);
    run_req("word_load_3fc", 1'b0, SIZE_WORD, 1'b0, 32'h3FC, 32'h0, 2, 1'b0, 32'h1357_9BDF, 1, 0);
    run_req("misaligned_41", 1'b0, SIZE_WORD, 1'b0, 32'h41, 32'h0, 1, 1'b1, 32'h0, 0, 0);
    run_req("range_400", 1'b0, SIZE_WORD, 1'b0, 32'h400, 32'h0, 1, 1'b1, 32'h0, 0, 0);
    run_req("range_store_hi", 1'b1, SIZE_WORD, 1'b0, 32'h8000_0040, 32'hFFFF_FFFF, 1, 1'b1, 32'h0, 0, 0);
    check("range_store_hi/mem", mem[8'h10], 32'hDEAD_BEEF);
    run_req("size_rsvd", 1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 1, 1'b1, 32'h0, 0, 0);

`ifdef MEM_ACCESS_SUBWORD_EN
    run_req("sbyte_43", 1'b0, SIZE_BYTE, 1'b1, 32'h43, 32'h0, 2, 1'b0, 32'hFFFF_FFDE, 1, 0);
    run_req("ubyte_43", 1'b0, SIZE_BYTE, 1'b0, 32'h43, 32'h0, 2, 1'b0, 32'h0000_00DE, 1, 0);
    run_req("half_store_42", 1'b1, SIZE_HALF, 1'b0, 32'h42, 32'h0000_1234, 3, 1'b0, 32'h0, 1, 1);
    check("half_store_42/mem", mem[8'h10], 32'h1234_BEEF);
    run_req("shalf_40", 1'b0, SIZE_HALF, 1'b1, 32'h40, 32'h0, 2, 1'b0, 32'hFFFF_BEEF, 1, 0);
    run_req("uhalf_40", 1'b0, SIZE_HALF, 1'b0, 32'h40, 32'h0, 2, 1'b0, 32'h0000_BEEF, 1, 0);
    run_req("shalf_42", 1'b0, SIZE_HALF, 1'b1, 32'h42, 32'h0, 2, 1'b0, 32'h0000_1234, 1, 0);
    run_req("byte_store_41", 1'b1, SIZE_BYTE, 1'b0, 32'h41, 32'hFFFF_FFA5, 3, 1'b0, 32'h0, 1, 1);
    check("byte_store_41/mem", mem[8'h10], 32'h1234_A5EF);
    run_req("sbyte_40", 1'b0, SIZE_BYTE, 1'b1, 32'h40, 32'h0, 2, 1'b0, 32'hFFFF_FFEF, 1, 0);
    run_req("half_misaligned_41", 1'b0, SIZE_HALF, 1'b0, 32'h41, 32'h0, 1, 1'b1, 32'h0, 0, 0);
    run_req("byte_range_400", 1'b1, SIZE_BYTE, 1'b0, 32'h400, 32'h55, 1, 1'b1, 32'h0, 0, 0);
    exp_final = 32'h1234_A5EF;

    wr0 = wr_pulses;
    resp0 = resp_pulses;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size = SIZE_BYTE;
    bus.req_signed = 1'b0;
    bus.req_addr = 32'h44;
    bus.req_wdata = 32'h77;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    check("rst_mid/in_rmw_rd", 32'(bus.mem_read), 32'd1);
`else
    run_req("byte_load_43", 1'b0, SIZE_BYTE, 1'b1, 32'h43, 32'h0, 1, 1'b1, 32'h0, 0, 0);
    run_req("half_store_42", 1'b1, SIZE_HALF, 1'b0, 32'h42, 32'h1234, 1, 1'b1, 32'h0, 0, 0);
    check("half_store_42/mem", mem[8'h10], 32'hDEAD_BEEF);
    exp_final = 32'hDEAD_BEEF;

    wr0 = wr_pulses;
    resp0 = resp_pulses;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size = SIZE_WORD;
    bus.req_signed = 1'b0;
    bus.req_addr = 32'h84;
    bus.req_wdata = 32'h55AA_55AA;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    check("rst_mid/in_wr", 32'(bus.mem_write), 32'd1);
    check("rst_mid/wr_data", bus.mem_wdata, 32'h55AA_55AA);
`endif
    reset = 1'b1;
    #1;
    check("rst_mid/req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_mid/mem_write", 32'(bus.mem_write), 32'd0);
    check("rst_mid/mem_read", 32'(bus.mem_read), 32'd0);
    check("rst_mid/resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_mid/mem_addr", bus.mem_addr, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
`ifdef MEM_ACCESS_SUBWORD_EN
    check("rst_mid/mem_unchanged", mem[8'h11], 32'h0102_0304);
`else
    check("rst_mid/mem_unchanged", mem[8'h21], 32'h0BAD_F00D);
`endif
    check("rst_mid/no_write", 32'(wr_pulses - wr0), 32'd0);
    check("rst_mid/no_resp", 32'(resp_pulses - resp0), 32'd0);

    run_req("load_after_rst", 1'b0, SIZE_WORD, 1'b0, 32'h40, 32'h0, 2, 1'b0, exp_final, 1, 0);
    check("rd_wr_exclusive", 32'(both_high), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter RAM_SIZE_BIT, default 8, meaning the number of word-address bits decoded by the downstream InstAndDataMemory.
REQ-002 The block SHALL have the port `clk`, input, width 1, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have the port `reset`, input, width 1, asynchronous active-high reset.
REQ-004 The block SHALL have the port `req_valid`, input, width 1, CPU access request.
REQ-005 The block SHALL have the port `req_ready`, output, width 1, request accepted this cycle when high together with `req_valid`.
REQ-006 The block SHALL have the port `req_write`, input, width 1: 1 = store, 0 = load.
REQ-007 The block SHALL have the port `req_size`, input, width 2: 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-008 The block SHALL have the port `req_signed`, input, width 1, sign-extending sub-word loads when 1.
REQ-009 The block SHALL have the port `req_addr`, input, width 32, byte address.
REQ-010 The block SHALL have the port `req_wdata`, input, width 32, store data, right-aligned for sub-word stores.
REQ-011 The block SHALL have the port `resp_valid`, output, width 1, a one-cycle completion pulse.
REQ-012 The block SHALL have the port `resp_rdata`, output, width 32, extended load data; it is 0 for stores and errors.
REQ-013 The block SHALL have the port `resp_err`, output, width 1, valid with `resp_valid`, flagging a misaligned, out-of-range or unsupported access.
REQ-014 The block SHALL have the port `mem_addr`, output, width 32, word-aligned address to memory, with bits [1:0] = 00.
REQ-015 The block SHALL have the port `mem_wdata`, output, width 32, write word to memory.
REQ-016 The block SHALL have the port `mem_read`, output, width 1, memory read enable; memory data is combinational.
REQ-017 The block SHALL have the port `mem_write`, output, width 1, memory write enable; memory writes on the `clk` rising edge.
REQ-018 The block SHALL have the port `mem_rdata`, input, width 32, memory read data.

Function
REQ-019 The FSM SHALL have the states IDLE, RD, WR, RMW_RD, RMW_WR and RESP; `req_ready` = 1 only in IDLE.
REQ-020 On acceptance, the block SHALL register `req_write`, `req_size`, `req_signed`, `req_addr` and `req_wdata`; later input changes SHALL have no effect on the access in progress.
REQ-021 The error check at acceptance SHALL flag:
- a half access with addr[0] = 1;
- a word access with addr[1:0] != 00;
- `req_size` = 11;
- any of addr[31:RAM_SIZE_BIT+2] nonzero.
REQ-022 On an error, the FSM SHALL go from IDLE to RESP with `resp_err` = 1, and `mem_read`/`mem_write` SHALL never assert for that request.
REQ-023 A load SHALL take the path IDLE -> RD -> RESP: in RD, `mem_read` = 1, and the selected lanes of `mem_rdata` are zero- or sign-extended and registered into `resp_rdata`.
REQ-024 A word store SHALL take the path IDLE -> WR -> RESP: in WR, `mem_write` = 1 and `mem_wdata` = `req_wdata`.
REQ-025 A sub-word store SHALL take the path IDLE -> RMW_RD -> RMW_WR -> RESP:
- in RMW_RD, `mem_read` = 1 and the merged word is latched;
- in RMW_WR, `mem_write` = 1 with the merged word.
REQ-026 Byte lanes SHALL be little-endian: byte k occupies bits [8k+7:8k], and a half at addr[1] = 1 occupies bits [31:16].
REQ-027 RESP SHALL last exactly one cycle with `resp_valid` = 1, then return to IDLE; the next request is acceptable the cycle after RESP.
REQ-028 Latency from the acceptance edge to the `resp_valid` cycle SHALL be:
- error: 1;
- load: 2;
- word store: 2;
- sub-word store: 3.
REQ-029 `mem_read` and `mem_write` SHALL never be high simultaneously, and SHALL be decoded from state only.

Reset
REQ-030 While `reset` = 1, the block SHALL hold the state at IDLE.
REQ-031 While `reset` = 1, `req_ready` SHALL be 1.
REQ-032 While `reset` = 1, `resp_valid`, `resp_err`, `mem_read` and `mem_write` SHALL be 0.
REQ-033 While `reset` = 1, `resp_rdata`, `mem_addr` and `mem_wdata` SHALL be 0.
REQ-034 Reset asserted mid-access SHALL abandon the access immediately, with no `mem_write` issued after assertion and no response.

Configuration
REQ-035 With macro MEM_ACCESS_SUBWORD_EN defined, byte and half accesses SHALL be supported per REQ-023 and REQ-025.
REQ-036 Without MEM_ACCESS_SUBWORD_EN, RMW_RD and RMW_WR SHALL be absent, and any `req_size` other than 10 SHALL produce `resp_err` = 1 per REQ-022.

Structure
REQ-037 Package mem_access_pkg SHALL hold the `req_size` encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD) and the FSM state encoding.
REQ-038 The combinational lane extract/extend and merge logic SHALL be sub-module byte_lane_unit, instantiated once.

Verification
REQ-039 Word load: with mem[0x10] = 0xDEADBEEF, a load of word 0x40 SHALL give `resp_valid` 2 cycles after acceptance with `resp_rdata` = 0xDEADBEEF and `resp_err` = 0.
REQ-040 Signed byte load at 0x43 from word 0xDEADBEEF SHALL give `resp_rdata` = 0xFFFFFFDE; the unsigned load SHALL give 0x000000DE.
REQ-041 A half store of 0x1234 at 0x42 over word 0xDEADBEEF SHALL read memory then write 0x1234BEEF, with `resp_valid` 3 cycles after acceptance.
REQ-042 A word load at 0x41, and an access at 0x400 with RAM_SIZE_BIT = 8, SHALL give `resp_err` = 1 after 1 cycle with no `mem_read` or `mem_write` pulse.
REQ-043 Asserting `reset` during RMW_RD of a byte store SHALL leave memory unchanged, with `resp_valid` never asserted and `req_ready` = 1.
REQ-044 With MEM_ACCESS_SUBWORD_EN undefined, a byte load SHALL give `resp_err` = 1 after 1 cycle.
